// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR command path: op encodings, address
// field layout and refresh timing defaults.
package ddr_pkg;

  // Command opcodes as seen by the SDRAM controller.
  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_REFRESH = 2'd2
  } ddr_op_e;

  // Internal grant decision of the arbiter for the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE    = 2'd0,
    GNT_READ    = 2'd1,
    GNT_WRITE   = 2'd2,
    GNT_REFRESH = 2'd3
  } ddr_gnt_e;

  // Address layout {bank, row, col}.
  localparam int BA_W       = 2;
  localparam int ROW_W      = 13;
  localparam int COL_W      = 9;
  localparam int COL_LSB    = 0;
  localparam int ROW_LSB    = COL_LSB + COL_W;
  localparam int BA_LSB     = ROW_LSB + ROW_W;
  localparam int DDR_ADDR_W = BA_W + ROW_W + COL_W;

  // 7.8 us at 133 MHz.
  localparam int DEFAULT_REFRESH_INTERVAL = 1040;
  localparam int DEFAULT_REFRESH_URGENT   = 4;
  localparam int DEFAULT_REFRESH_MAX      = 8;

  // Build a command address from its bank/row/column fields.
  function automatic logic [DDR_ADDR_W-1:0] ddr_addr(
    input logic [BA_W-1:0]  ba,
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col
  );
    return {ba, row, col};
  endfunction

endpackage

// File: rtl/ddr_write_fifo.sv
// Small synchronous FIFO buffering draw-engine writes ahead of arbitration.
// Push when full and pop when empty are ignored, so callers may be loose.
module ddr_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk133_p,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en, pop_en;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  // Head entry is visible without a read cycle so a grant can pop and load
  // the command register at the same edge.
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer advance with explicit wrap and occupancy tracking.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk133_p) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk133_p) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/ddr_request_arbiter.sv
// Merges video reads, buffered draw writes and periodic auto-refresh into a
// single registered command stream towards the DDR controller.
module ddr_request_arbiter
  import ddr_pkg::*;
#(
  parameter int ADDR_W           = DDR_ADDR_W,
  parameter int DATA_W           = 16,
  parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
  parameter int REFRESH_URGENT   = DEFAULT_REFRESH_URGENT,
  parameter int REFRESH_MAX      = DEFAULT_REFRESH_MAX
) (
  input  logic              clk133_p,
  input  logic              rst,
  input  logic              init_done,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              cmd_valid,
  output logic [1:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_ready,
  output logic              refresh_overrun
);

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_W     = ADDR_W + DATA_W;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_W      = $clog2(REFRESH_INTERVAL);
  localparam int PND_W      = $clog2(REFRESH_MAX + 1);

  localparam logic [TMR_W-1:0]      TMR_LAST   = TMR_W'(REFRESH_INTERVAL - 1);
  localparam logic [PND_W-1:0]      PND_URGENT = PND_W'(REFRESH_URGENT);
  localparam logic [PND_W-1:0]      PND_MAX    = PND_W'(REFRESH_MAX);
  localparam logic [FIFO_CNT_W-1:0] FIFO_FULL  = FIFO_CNT_W'(FIFO_DEPTH);

  // Output command slot.
  logic              cmd_valid_q, cmd_valid_d;
  ddr_op_e           cmd_op_q, cmd_op_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;

  // Refresh bookkeeping.
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [PND_W-1:0]  pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              refresh_fire;

  // Arbitration.
  logic              slot_free;
  ddr_gnt_e          gnt;

  // Write FIFO interface.
  logic              fifo_push;
  logic              fifo_pop;
  logic [FIFO_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;

  // The slot can take a new command if it is empty or being drained now.
  assign slot_free = !cmd_valid_q || cmd_ready;

  // wr_ready follows registered occupancy only; a same-cycle pop does not
  // open a slot for the producer.
  assign wr_ready  = (fifo_count != FIFO_FULL);
  assign fifo_push = wr_valid && !fifo_full;
  assign fifo_pop  = (gnt == GNT_WRITE);
  assign rd_ready  = (gnt == GNT_READ);

  ddr_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_write_fifo (
    .clk133_p (clk133_p),
    .rst      (rst),
    .push_i   (fifo_push),
    .wdata_i  ({wr_addr, wr_data}),
    .pop_i    (fifo_pop),
    .rdata_o  (fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  // Fixed-priority grant: urgent refresh, read, any refresh, write.
  always_comb begin
    gnt = GNT_NONE;
    if (slot_free && init_done) begin
      if (pending_q >= PND_URGENT) begin
        gnt = GNT_REFRESH;
      end else if (rd_valid) begin
        gnt = GNT_READ;
      end else if (pending_q != '0) begin
        gnt = GNT_REFRESH;
      end else if (!fifo_empty) begin
        gnt = GNT_WRITE;
      end
    end
  end

  // Refresh interval timer; frozen at zero until the controller is up.
  always_comb begin
    refresh_fire = init_done && (timer_q == TMR_LAST);
    if (!init_done || refresh_fire) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  // Pending-refresh counter with saturation and sticky overrun flag.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (refresh_fire && (gnt != GNT_REFRESH)) begin
      if (pending_q == PND_MAX) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = pending_q + PND_W'(1);
      end
    end else if (!refresh_fire && (gnt == GNT_REFRESH)) begin
      pending_d = pending_q - PND_W'(1);
    end
  end

  // Output slot: hold while stalled, otherwise load the grant or go idle.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if (slot_free) begin
      cmd_valid_d = 1'b0;
      case (gnt)
        GNT_READ: begin
          cmd_valid_d = 1'b1;
          cmd_op_d    = OP_READ;
          cmd_addr_d  = rd_addr;
          cmd_wdata_d = '0;
        end
        GNT_WRITE: begin
          cmd_valid_d = 1'b1;
          cmd_op_d    = OP_WRITE;
          cmd_addr_d  = fifo_rdata[FIFO_W-1:DATA_W];
          cmd_wdata_d = fifo_rdata[DATA_W-1:0];
        end
        GNT_REFRESH: begin
          cmd_valid_d = 1'b1;
          cmd_op_d    = OP_REFRESH;
          cmd_addr_d  = '0;
          cmd_wdata_d = '0;
        end
        default: begin
          cmd_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers; reset drops any held command.
  always_ff @(posedge clk133_p) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_READ;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      timer_q     <= '0;
      pending_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cmd_valid       = cmd_valid_q;
  assign cmd_op          = cmd_op_q;
  assign cmd_addr        = cmd_addr_q;
  assign cmd_wdata       = cmd_wdata_q;
  assign refresh_overrun = overrun_q;

endmodule

// File: tb/tb_ddr_request_arbiter.sv
// Directed bench for ddr_request_arbiter: expected commands are queued by the
// stimulus, a monitor pops and compares at each accepted command.
`timescale 1ns/1ps
module tb_ddr_request_arbiter;
  import ddr_pkg::*;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  logic              clk133_p = 1'b0;
  logic              rst = 1'b1;
  logic              init_done = 1'b0;
  logic              rd_valid = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_ready;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_ready = 1'b0;
  logic              refresh_overrun;

  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  cmd_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   n_cmds  = 0;

  always #5 clk133_p = ~clk133_p;

  ddr_request_arbiter dut (
    .clk133_p        (clk133_p),
    .rst             (rst),
    .init_done       (init_done),
    .rd_valid        (rd_valid),
    .rd_addr         (rd_addr),
    .rd_ready        (rd_ready),
    .wr_valid        (wr_valid),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .cmd_valid       (cmd_valid),
    .cmd_op          (cmd_op),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .cmd_ready       (cmd_ready),
    .refresh_overrun (refresh_overrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    cmd_t c;
    c.op   = op;
    c.addr = addr;
    c.data = data;
    exp_q.push_back(c);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk133_p);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    init_done = 1'b0;
    rd_valid  = 1'b0;
    wr_valid  = 1'b0;
    cmd_ready = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  // Monitor: every accepted command must match the head of the queue.
  always @(negedge clk133_p) begin
    cmd_t act;
    cmd_t e;
    if (!rst && cmd_valid && cmd_ready) begin
      act.op   = cmd_op;
      act.addr = cmd_addr;
      act.data = cmd_wdata;
      n_cmds++;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd: got op=%0d addr=0x%06h data=0x%04h, expected no command",
                 act.op, act.addr, act.data);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL cmd_%0d: got op=%0d addr=0x%06h data=0x%04h, expected op=%0d addr=0x%06h data=0x%04h",
                   n_cmds, act.op, act.addr, act.data, e.op, e.addr, e.data);
        end else begin
          $display("cmd %0d ok: op=%0d addr=0x%06h data=0x%04h", n_cmds, act.op, act.addr, act.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [ADDR_W-1:0] wa [5];
  logic [DATA_W-1:0] wd [5];
  localparam logic [ADDR_W-1:0] R3 = 24'h1F0001;
  localparam logic [ADDR_W-1:0] RA = 24'h2A5A5A;

  initial begin
    wa[0] = ddr_addr(2'd0, 13'h0001, 9'h010);
    wa[1] = ddr_addr(2'd1, 13'h0123, 9'h020);
    wa[2] = ddr_addr(2'd2, 13'h1FFF, 9'h1FF);
    wa[3] = ddr_addr(2'd3, 13'h0AAA, 9'h000);
    wa[4] = ddr_addr(2'd1, 13'h1555, 9'h155);
    wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333;
    wd[3] = 16'h4444; wd[4] = 16'h5555;

    // Reset state.
    do_reset();
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_cmd_op", 64'(cmd_op), 64'd0);
    check("rst_cmd_addr", 64'(cmd_addr), 64'd0);
    check("rst_cmd_wdata", 64'(cmd_wdata), 64'd0);
    check("rst_overrun", 64'(refresh_overrun), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_rd_ready", 64'(rd_ready), 64'd0);

    // Idle refresh: fire at edge 1040, command visible after edge 1041.
    cmd_ready = 1'b1;
    init_done = 1'b1;
    exp_cmd(OP_REFRESH, '0, '0);
    step(1040);
    check("ref_not_yet", 64'(cmd_valid), 64'd0);
    step(1);
    check("ref_valid_1041", 64'(cmd_valid), 64'd1);
    check("ref_op", 64'(cmd_op), 64'(OP_REFRESH));
    check("ref_addr", 64'(cmd_addr), 64'd0);
    step(6);
    check("ref_idle_after", 64'(cmd_valid), 64'd0);
    check("ref_queue_drained", 64'(exp_q.size()), 64'd0);

    // Read beats write in the same cycle; write follows next cycle.
    do_reset();
    init_done = 1'b1;
    cmd_ready = 1'b1;
    rd_valid = 1'b1; rd_addr = 24'h012345;
    wr_valid = 1'b1; wr_addr = 24'h0ABCDE; wr_data = 16'hAAAA;
    exp_cmd(OP_READ, 24'h012345, '0);
    exp_cmd(OP_WRITE, 24'h0ABCDE, 16'hAAAA);
    #1;
    check("rw_rd_ready", 64'(rd_ready), 64'd1);
    step(1);
    rd_valid = 1'b0; wr_valid = 1'b0;
    #1;
    check("rw_first_op", 64'(cmd_op), 64'(OP_READ));
    check("rw_first_addr", 64'(cmd_addr), 64'h012345);
    step(1);
    check("rw_second_op", 64'(cmd_op), 64'(OP_WRITE));
    check("rw_second_addr", 64'(cmd_addr), 64'h0ABCDE);
    check("rw_second_data", 64'(cmd_wdata), 64'hAAAA);
    step(3);
    check("rw_idle", 64'(cmd_valid), 64'd0);

    // FIFO fill behind a stalled read, then drain in push order.
    do_reset();
    init_done = 1'b1;
    rd_valid = 1'b1; rd_addr = R3;
    exp_cmd(OP_READ, R3, '0);
    step(1);
    rd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_addr = wa[i]; wr_data = wd[i];
      exp_cmd(OP_WRITE, wa[i], wd[i]);
      #1;
      check($sformatf("fill_wr_ready_%0d", i), 64'(wr_ready), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) step(1);
    end
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("fill_held_wr_ready", 64'(wr_ready), 64'd0);
      check("fill_held_valid", 64'(cmd_valid), 64'd1);
      check("fill_held_op", 64'(cmd_op), 64'(OP_READ));
      check("fill_held_addr", 64'(cmd_addr), 64'(R3));
    end
    cmd_ready = 1'b1;
    #1;
    check("fill_release_still_full", 64'(wr_ready), 64'd0);
    step(1);
    check("fill_release_ready", 64'(wr_ready), 64'd1);
    step(1);
    wr_valid = 1'b0;
    step(8);
    check("fill_queue_drained", 64'(exp_q.size()), 64'd0);

    // Long stall: 9 fires, pending saturates at 8 and overrun latches.
    do_reset();
    init_done = 1'b1;
    rd_valid = 1'b1; rd_addr = RA;
    exp_cmd(OP_READ, RA, '0);
    step(1);
    step(8999);
    check("stall_overrun_before", 64'(refresh_overrun), 64'd0);
    check("stall_addr_stable", 64'(cmd_addr), 64'(RA));
    step(400);
    check("stall_overrun_set", 64'(refresh_overrun), 64'd1);
    // Pending 8,7,6,5,4 are urgent -> 5 refreshes, then read, then 3 more.
    for (int k = 0; k < 5; k++) exp_cmd(OP_REFRESH, '0, '0);
    exp_cmd(OP_READ, RA, '0);
    for (int k = 0; k < 3; k++) exp_cmd(OP_REFRESH, '0, '0);
    cmd_ready = 1'b1;
    #1;
    check("stall_rd_blocked", 64'(rd_ready), 64'd0);
    step(5);
    check("stall_rd_granted", 64'(rd_ready), 64'd1);
    step(1);
    rd_valid = 1'b0;
    step(10);
    check("stall_queue_drained", 64'(exp_q.size()), 64'd0);
    check("stall_overrun_sticky", 64'(refresh_overrun), 64'd1);
    do_reset();
    check("overrun_cleared", 64'(refresh_overrun), 64'd0);

    // Reset with a held command and three buffered writes.
    init_done = 1'b1;
    rd_valid = 1'b1; rd_addr = 24'h333333;
    step(1);
    rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = wa[i]; wr_data = wd[i];
      step(1);
    end
    wr_valid = 1'b0;
    check("mid_held_valid", 64'(cmd_valid), 64'd1);
    rst = 1'b1;
    step(1);
    check("mid_rst_valid", 64'(cmd_valid), 64'd0);
    check("mid_rst_wr_ready", 64'(wr_ready), 64'd1);
    rst = 1'b0;
    cmd_ready = 1'b1;
    step(20);
    check("mid_no_stale", 64'(cmd_valid), 64'd0);

    // init_done low: no grants, timer frozen, FIFO kept.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_addr = wa[3 + i]; wr_data = wd[3 + i];
      step(1);
    end
    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 24'h444444;
    cmd_ready = 1'b1;
    #1;
    check("noinit_rd_ready", 64'(rd_ready), 64'd0);
    step(1500);
    check("noinit_valid", 64'(cmd_valid), 64'd0);
    check("noinit_rd_ready_late", 64'(rd_ready), 64'd0);
    rd_valid = 1'b0;
    init_done = 1'b1;
    exp_cmd(OP_WRITE, wa[3], wd[3]);
    exp_cmd(OP_WRITE, wa[4], wd[4]);
    exp_cmd(OP_REFRESH, '0, '0);
    step(1040);
    check("noinit_ref_not_yet", 64'(cmd_valid), 64'd0);
    step(1);
    check("noinit_ref_valid", 64'(cmd_valid), 64'd1);
    check("noinit_ref_op", 64'(cmd_op), 64'(OP_REFRESH));
    step(4);
    check("noinit_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
